// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with valid/ready handshakes on both sides.
// Shifts and rotates advance one bit position per cycle; every other op completes in one cycle.
module alu_seq #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   alu_op,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] rslt,
    output logic         taken,
    output logic         flag_z,
    output logic         flag_c,
    output logic         flag_n
);

    localparam int unsigned SW = $clog2(W);
    localparam int unsigned CW = SW + 1;
    localparam logic [W-1:0] W_AMT = W'(W);

    localparam logic [3:0] OP_PASS = 4'h0;
    localparam logic [3:0] OP_SHR  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_POS  = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_BEQ  = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_ROR  = 4'h9;
    localparam logic [3:0] OP_SUB  = 4'hA;
    localparam logic [3:0] OP_AND  = 4'hB;
    localparam logic [3:0] OP_OR   = 4'hC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     op_q, op_d;
    logic [W-1:0]   work_q, work_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   rslt_q, rslt_d;
    logic           taken_q, taken_d;
    logic           flag_z_q, flag_z_d;
    logic           flag_c_q, flag_c_d;
    logic           flag_n_q, flag_n_d;
    logic           out_valid_q, out_valid_d;
    logic           in_ready_q, in_ready_d;

    logic           is_shift;
    logic [CW-1:0]  amt;
    logic [W:0]     sum;
    logic [W-1:0]   step_val;
    logic           step_carry;
    logic           load;
    logic [W-1:0]   fin_r;
    logic           fin_c;
    logic           fin_t;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            work_q      <= '0;
            cnt_q       <= '0;
            rslt_q      <= '0;
            taken_q     <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_c_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            rslt_q      <= rslt_d;
            taken_q     <= taken_d;
            flag_z_q    <= flag_z_d;
            flag_c_q    <= flag_c_d;
            flag_n_q    <= flag_n_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        rslt_d      = rslt_q;
        taken_d     = taken_q;
        flag_z_d    = flag_z_q;
        flag_c_d    = flag_c_q;
        flag_n_d    = flag_n_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        load        = 1'b0;
        fin_r       = '0;
        fin_c       = 1'b0;
        fin_t       = 1'b0;

        is_shift = (alu_op == OP_SHR) || (alu_op == OP_SHL) || (alu_op == OP_ROR);
        sum      = {1'b0, in_a} + {1'b0, in_b};

        // Rotate amount wraps modulo W; shift amounts saturate at W.
        if (alu_op == OP_ROR) begin
            amt = CW'(in_b[SW-1:0]);
        end else if (in_b >= W_AMT) begin
            amt = CW'(W);
        end else begin
            amt = CW'(in_b);
        end

        step_val   = work_q;
        step_carry = 1'b0;
        case (op_q)
            OP_SHL: begin
                step_val   = {work_q[W-2:0], 1'b0};
                step_carry = work_q[W-1];
            end
            OP_ROR: begin
                step_val   = {work_q[0], work_q[W-1:1]};
                step_carry = work_q[0];
            end
            default: begin
                step_val   = {1'b0, work_q[W-1:1]};
                step_carry = work_q[0];
            end
        endcase

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d   = alu_op;
                    work_d = in_a;
                    cnt_d  = amt;
                    if (is_shift && (amt != '0)) begin
                        state_d = EXEC;
                    end else begin
                        state_d = DONE;
                        load    = 1'b1;
                        case (alu_op)
                            OP_PASS: fin_r = in_a;
                            OP_SHR, OP_SHL, OP_ROR: fin_r = in_a;
                            OP_ADD: begin
                                fin_r = sum[W-1:0];
                                fin_c = sum[W];
                            end
                            OP_POS:  fin_t = (in_a != '0);
                            OP_XOR:  fin_r = in_a ^ in_b;
                            OP_BEQ:  fin_t = (in_a == '0);
                            OP_LW, OP_SW: fin_r = in_b;
                            OP_SUB: begin
                                fin_r = in_a - in_b;
                                fin_c = (in_a < in_b);
                            end
                            OP_AND:  fin_r = in_a & in_b;
                            OP_OR:   fin_r = in_a | in_b;
                            default: fin_r = '0;
                        endcase
                    end
                end
            end
            EXEC: begin
                work_d = step_val;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    load    = 1'b1;
                    fin_r   = step_val;
                    fin_c   = step_carry;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            rslt_d   = fin_r;
            taken_d  = fin_t;
            flag_c_d = fin_c;
            flag_z_d = (fin_r == '0);
            flag_n_d = fin_r[W-1];
        end

        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign rslt      = rslt_q;
    assign taken     = taken_q;
    assign flag_z    = flag_z_q;
    assign flag_c    = flag_c_q;
    assign flag_n    = flag_n_q;

endmodule
